// File: rtl/if_stage_bp.sv
// Fetch front end: registered PC with a tagged, direct-mapped BTB and a 2-bit counter per entry.
// Latency: pred_* are combinational from pc; the chosen next PC appears one cycle later; updates are visible next cycle.
// Backpressure: PCWrite=0 holds pc (redirect still wins); updates are always accepted, one per cycle.
//
// Ports:
//   clk, rst (synchronous, active-low)
//   PCWrite, redirect, redirect_pc       - next-PC control from hazard unit / EX
//   upd_valid, upd_pc, upd_taken,
//   upd_target                           - resolved-branch training from EX
//   pc, pred_hit, pred_taken, pred_target - fetch address and its prediction
module if_stage_bp #(
  parameter int          ENTRIES  = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [1:0]  CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  output logic [31:0] pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 32 - IDX_W - 2;

  logic [ENTRIES-1:0] valid;
  logic [TAG_W-1:0]   tag_tbl [ENTRIES];
  logic [31:0]        tgt_tbl [ENTRIES];
  logic [1:0]         ctr_tbl [ENTRIES];

  // Lookup side, driven by the current fetch address.
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;

  assign lk_idx      = pc[IDX_W+1:2];
  assign lk_tag      = pc[31:IDX_W+2];
  assign pred_hit    = valid[lk_idx] && (tag_tbl[lk_idx] == lk_tag);
  assign pred_taken  = pred_hit && ctr_tbl[lk_idx][1];
  assign pred_target = tgt_tbl[lk_idx];

  // Next-PC selection: redirect beats stall, stall beats prediction.
  logic [31:0] pc_next;

  always_comb begin
    pc_next = pc + 32'd4;
    if (redirect)
      pc_next = redirect_pc;
    else if (!PCWrite)
      pc_next = pc;
    else if (pred_taken)
      pc_next = pred_target;
  end

  always_ff @(posedge clk) begin
    if (!rst)
      pc <= RESET_PC;
    else
      pc <= pc_next;
  end

  // Update side, driven by the resolved branch from EX.
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic             up_hit;
  logic [1:0]       up_ctr;
  logic [1:0]       ctr_next;

  assign up_idx = upd_pc[IDX_W+1:2];
  assign up_tag = upd_pc[31:IDX_W+2];
  assign up_hit = valid[up_idx] && (tag_tbl[up_idx] == up_tag);
  assign up_ctr = ctr_tbl[up_idx];

  always_comb begin
    ctr_next = up_ctr;
    if (upd_taken && up_ctr != 2'b11)
      ctr_next = up_ctr + 2'd1;
    else if (!upd_taken && up_ctr != 2'b00)
      ctr_next = up_ctr - 2'd1;
  end

  // Tags and targets are not reset: valid=0 makes them irrelevant, and reset
  // must still block any write so a flushed table stays empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid <= '0;
      for (int i = 0; i < ENTRIES; i++)
        ctr_tbl[i] <= CTR_INIT;
    end else if (upd_valid) begin
      if (up_hit) begin
        ctr_tbl[up_idx] <= ctr_next;
        if (upd_taken)
          tgt_tbl[up_idx] <= upd_target;
      end else if (upd_taken) begin
        // Miss on a taken branch allocates over whatever sat in this slot,
        // starting weakly taken so one not-taken flips the prediction.
        valid[up_idx]   <= 1'b1;
        tag_tbl[up_idx] <= up_tag;
        tgt_tbl[up_idx] <= upd_target;
        ctr_tbl[up_idx] <= 2'b10;
      end
    end
  end

endmodule

// File: tb/tb_if_stage_bp.sv
// Directed bench for if_stage_bp (ENTRIES=16, RESET_PC=0x100).
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
// Every expected value below is hand-computed from the block's behaviour.
module tb_if_stage_bp;

  logic        clk;
  logic        rst;
  logic        PCWrite;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic [31:0] pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;

  int checks = 0;
  int failures = 0;

  if_stage_bp #(
    .ENTRIES (16),
    .RESET_PC(32'h0000_0100),
    .CTR_INIT(2'b01)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCWrite    (PCWrite),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .upd_valid  (upd_valid),
    .upd_pc     (upd_pc),
    .upd_taken  (upd_taken),
    .upd_target (upd_target),
    .pc         (pc),
    .pred_hit   (pred_hit),
    .pred_taken (pred_taken),
    .pred_target(pred_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    redirect  = 1'b0;
    upd_valid = 1'b0;
    upd_taken = 1'b0;
    PCWrite   = 1'b1;
  endtask

  task automatic upd(input logic [31:0] a, input logic tk, input logic [31:0] t);
    upd_valid  = 1'b1;
    upd_pc     = a;
    upd_taken  = tk;
    upd_target = t;
  endtask

  task automatic redir(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
  endtask

  initial begin
    rst = 1'b0; PCWrite = 1'b1; redirect = 1'b0; redirect_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
    step(); step();
    rst = 1'b1;

    // Reset state and sequential fetch.
    chk("rst_pc", pc, 32'h100);
    chk("rst_hit", {31'b0, pred_hit}, 32'd0);
    chk("rst_taken", {31'b0, pred_taken}, 32'd0);
    step();
    chk("seq_pc1", pc, 32'h104);
    chk("seq_hit1", {31'b0, pred_hit}, 32'd0);
    step();
    chk("seq_pc2", pc, 32'h108);
    chk("seq_hit2", {31'b0, pred_hit}, 32'd0);

    // Allocate 0x108 -> 0x200 while holding pc; no bypass in the update cycle.
    upd(32'h108, 1'b1, 32'h200);
    PCWrite = 1'b0;
    chk("nobyp_hit", {31'b0, pred_hit}, 32'd0);
    step();
    idle();
    chk("alloc_pc_held", pc, 32'h108);
    chk("alloc_hit", {31'b0, pred_hit}, 32'd1);
    chk("alloc_taken", {31'b0, pred_taken}, 32'd1);
    chk("alloc_tgt", pred_target, 32'h200);
    step();
    chk("pred_jump_pc", pc, 32'h200);

    // Hysteresis: 10 -> 01 (not taken), fall through.
    upd(32'h108, 1'b0, 32'h0);
    redir(32'h108);
    step();
    idle();
    chk("hyst_nt_hit", {31'b0, pred_hit}, 32'd1);
    chk("hyst_nt_taken", {31'b0, pred_taken}, 32'd0);
    chk("hyst_nt_tgt", pred_target, 32'h200);
    step();
    chk("hyst_fall_pc", pc, 32'h10C);
    // 01 -> 10 -> 11
    upd(32'h108, 1'b1, 32'h200);
    step();
    upd(32'h108, 1'b1, 32'h200);
    redir(32'h108);
    step();
    idle();
    chk("hyst_st_pc", pc, 32'h108);
    chk("hyst_st_taken", {31'b0, pred_taken}, 32'd1);
    // 11 -> 10: still predicted taken.
    upd(32'h108, 1'b0, 32'h0);
    PCWrite = 1'b0;
    step();
    idle();
    chk("hyst_wt_taken", {31'b0, pred_taken}, 32'd1);
    step();
    chk("hyst_wt_pc", pc, 32'h200);

    // Tag aliasing: 0x148 shares idx 2 with 0x108.
    redir(32'h148);
    step();
    idle();
    chk("alias_pc", pc, 32'h148);
    chk("alias_hit", {31'b0, pred_hit}, 32'd0);
    upd(32'h148, 1'b0, 32'h0);
    step();
    idle();
    chk("alias_next_pc", pc, 32'h14C);
    redir(32'h108);
    step();
    idle();
    chk("alias_keep_hit", {31'b0, pred_hit}, 32'd1);
    chk("alias_keep_taken", {31'b0, pred_taken}, 32'd1);

    // Priority: redirect beats stall; stall holds; then resume.
    PCWrite = 1'b0;
    redir(32'h300);
    step();
    redirect = 1'b0;
    chk("prio_redir_pc", pc, 32'h300);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc", pc, 32'h300);
    end
    PCWrite = 1'b1;
    step();
    chk("resume_pc", pc, 32'h304);

    // PC wraps modulo 2^32.
    redir(32'hFFFF_FFFC);
    step();
    idle();
    chk("wrap_pre", pc, 32'hFFFF_FFFC);
    step();
    chk("wrap_pc", pc, 32'h0);

    // Mid-run reset dominates redirect/update and flushes the table.
    redir(32'h108);
    step();
    idle();
    chk("pre_rst_hit", {31'b0, pred_hit}, 32'd1);
    rst = 1'b0;
    redir(32'h300);
    upd(32'h308, 1'b1, 32'h400);
    step();
    rst = 1'b1;
    idle();
    chk("midrst_pc", pc, 32'h100);
    chk("midrst_hit", {31'b0, pred_hit}, 32'd0);
    redir(32'h108);
    step();
    idle();
    chk("flush_hit", {31'b0, pred_hit}, 32'd0);
    redir(32'h308);
    step();
    idle();
    chk("rst_blk_upd_hit", {31'b0, pred_hit}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage_bp.md
# if_stage_bp

Parametrised instruction-fetch front end with integrated branch prediction: holds the PC and predicts the next fetch address each cycle. Prediction uses a direct-mapped, tagged BTB whose entries each carry a 2-bit saturating counter. Sits ahead of the instruction memory and the IF/ID register, and receives resolved-branch updates and mispredict redirects from EX. Unlike the fixed-size predictor it replaces, depth and reset PC are configurable, and the BTB is tag-checked so aliasing branches miss instead of hitting.

## Interface
- ENTRIES, 16, BTB/counter entries; power of two, 2..1024; IDX_W = log2(ENTRIES)
- RESET_PC, 32'h0000_0000, PC value after reset
- CTR_INIT, 2'b01, counter value written at reset
- clk  in  1  single clock, rising edge
- rst  in  1  reset; one clock; reset is synchronous and active-low
- PCWrite  in  1  1 = PC may advance; 0 = hold (hazard stall)
- redirect  in  1  EX mispredict; load redirect_pc
- redirect_pc  in  32  corrected fetch address
- upd_valid  in  1  resolved branch/jump update this cycle
- upd_pc  in  32  PC of the resolved branch
- upd_taken  in  1  actual direction
- upd_target  in  32  actual target
- pc  out  32  current fetch address (to instruction memory, IF/ID)
- pred_hit  out  1  BTB tag hit for pc
- pred_taken  out  1  predicted taken for pc
- pred_target  out  32  predicted target for pc (valid when pred_hit)

## Operation
- Indexing: idx = addr[IDX_W+1:2]; tag = addr[31:IDX_W+2]; addr[1:0] ignored.
- Entry state: valid (1), tag, target (32), ctr (2): 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup (combinational on pc): pred_hit = valid[idx] & (tag[idx]==tag(pc)); pred_taken = pred_hit & ctr[idx][1]; pred_target = target[idx].
- Next-PC priority, evaluated each edge:
  - redirect=1 -> redirect_pc (regardless of PCWrite)
  - else PCWrite=0 -> hold pc
  - else pred_taken -> pred_target
  - else pc+4 (wraps modulo 2^32)
- Update when upd_valid=1, using upd_pc's idx/tag:
  - Hit: ctr += 1 if taken (saturate at 11), ctr -= 1 if not taken (saturate at 00); target <= upd_target only when taken.
  - Miss and taken: allocate/replace; valid=1, tag, target=upd_target, ctr=10.
  - Miss and not taken: no change.
- Updates are independent of PCWrite and redirect; the update and a redirect in the same cycle both take effect.

## Timing
- Reset (rst=0 at an edge): pc=RESET_PC; all valid=0; all ctr=CTR_INIT; tags/targets don't-care. Outputs on the first cycle after reset: pc=RESET_PC, pred_hit=0, pred_taken=0. rst dominates redirect, update and PCWrite. Reset asserted mid-run flushes all predictor state in one cycle.
- pc is registered; pred_* are combinational from pc and table state in the same cycle; the next-PC choice is visible on pc one cycle later.
- Update latency: written at the upd_valid edge and visible to lookups from the next cycle. A lookup of the same idx in the update cycle sees the pre-update state; no bypass.
- Throughput: one lookup and one update per cycle.
- Stall: while PCWrite=0 and redirect=0, pc and pred_* stay stable (unless an update rewrites the entry at pc's idx; pred_* then changes the following cycle, pc still held).

## Test plan
- Reset/sequential: RESET_PC=0x100, rst low for 2 cycles, then PCWrite=1 -> pc 0x100, 0x104, 0x108; pred_hit=0 throughout.
- Allocate and predict: upd_valid, upd_pc=0x108, taken, target=0x200. Next fetch of 0x108 -> pred_hit=1, pred_taken=1, pc goes to 0x200 the next cycle.
- Counter hysteresis: starting from ctr=10 at 0x108, apply not-taken -> ctr=01, pred_taken=0, fall through to 0x10C. Then taken twice -> ctr=11. Then one not-taken -> still predicted taken.
- Tag aliasing (ENTRIES=16): entry allocated for 0x108, then fetch 0x148 (same idx, different tag) -> pred_hit=0, next pc 0x14C. A not-taken update at 0x148 leaves the 0x108 entry intact.
- Priority: PCWrite=0 with redirect=1, redirect_pc=0x300 -> pc=0x300. PCWrite=0 alone -> pc held for N cycles, then resumes at +4 or predicted target.
- Same-cycle update/lookup and mid-run reset: an update to the idx of the current pc leaves pred_* unchanged that cycle and changes it the next. Then rst=0 for one cycle -> pc=RESET_PC and a previously hit address now shows pred_hit=0.
